// File: rtl/alu_16_sequencer_pkg.sv
// Shared types for the 16-bit sequencer: request opcodes, alu opcodes and F-register bit indices.
// The flag indices also describe the alu's status_flag bit positions.
package alu_16_sequencer_pkg;

    typedef enum logic [1:0] {
        ADD16 = 2'd0,
        SUB16 = 2'd1,
        INC16 = 2'd2,
        DEC16 = 2'd3
    } alu16_op;

    typedef enum logic [3:0] {
        ADD = 4'h0,
        SUB = 4'h1
    } alu_op;

    localparam int FLAG_C = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_H = 4;
    localparam int FLAG_Z = 6;
    localparam int FLAG_S = 7;

    function automatic logic is_sub(input alu16_op op);
        return (op == SUB16) || (op == DEC16);
    endfunction

    function automatic logic is_unary(input alu16_op op);
        return (op == INC16) || (op == DEC16);
    endfunction

endpackage

// File: rtl/alu_16_sequencer_flags.sv
// Combinational composer of the F-format flag byte {S,Z,0,H,0,V,N,C} for a 16-bit result.
module alu_16_sequencer_flags
    import alu_16_sequencer_pkg::*;
(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] r,
    input  logic        c1,
    input  logic        c2,
    input  logic        h1,
    input  logic        h2,
    input  logic        sub,
    output logic [7:0]  flags
);

    logic sign_match;

    always_comb begin
        flags      = 8'h00;
        // Overflow needs same-sign operands for add, opposite-sign operands for subtract.
        sign_match = sub ? (x[15] != y[15]) : (x[15] == y[15]);
        flags[FLAG_C] = c1 | c2;
        flags[FLAG_N] = sub;
        flags[FLAG_V] = sign_match & (r[15] != x[15]);
        flags[FLAG_H] = h1 | h2;
        flags[FLAG_Z] = (r == 16'h0000);
        flags[FLAG_S] = r[15];
    end

endmodule

// File: rtl/alu_16_sequencer.sv
// Runs 16-bit add/sub/inc/dec on an 8-bit carry-less alu as LO, HI and optional FIX byte passes.
module alu_16_sequencer
    import alu_16_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        ready,
    input  alu16_op     op16,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  flags,
    output logic        alu_en,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output alu_op       alu_opcode,
    input  logic [7:0]  alu_out,
    input  logic [7:0]  alu_status
);

    typedef enum logic [2:0] {IDLE, LO, HI, FIX, DONE} seq_state;

    seq_state    state_q, state_d;
    logic [15:0] x_q, y_q, y_eff;
    alu16_op     op_q;
    logic [7:0]  lo_q;
    logic        c0_q, c1_q, h1_q;
    logic        accept;
    logic        c1_in, h1_in, c2_in, h2_in;
    logic [15:0] r_next;
    logic [7:0]  flags_next;
    logic        unused_status;

    assign ready         = (state_q == IDLE);
    assign accept        = ready & start;
    assign y_eff         = is_unary(op16) ? 16'h0001 : y;
    assign unused_status = ^{alu_status[7:5], alu_status[3:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LO;
            LO:      state_d = HI;
            HI:      state_d = c0_q ? FIX : DONE;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The final byte pass is still on alu_out, so the result is composed on the edge that leaves it.
    assign c1_in  = (state_q == HI) ? alu_status[FLAG_C] : c1_q;
    assign h1_in  = (state_q == HI) ? alu_status[FLAG_H] : h1_q;
    assign c2_in  = (state_q == FIX) & alu_status[FLAG_C];
    assign h2_in  = (state_q == FIX) & alu_status[FLAG_H];
    assign r_next = {alu_out, lo_q};

    alu_16_sequencer_flags u_flags (
        .x     (x_q),
        .y     (y_q),
        .r     (r_next),
        .c1    (c1_in),
        .c2    (c2_in),
        .h1    (h1_in),
        .h2    (h2_in),
        .sub   (is_sub(op_q)),
        .flags (flags_next)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            x_q  <= x;
            y_q  <= y_eff;
            op_q <= op16;
        end
        if (state_q == LO) begin
            lo_q <= alu_out;
            c0_q <= alu_status[FLAG_C];
        end
        if (state_q == HI) begin
            c1_q <= alu_status[FLAG_C];
            h1_q <= alu_status[FLAG_H];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done       <= 1'b0;
            result     <= 16'h0000;
            flags      <= 8'h00;
            alu_en     <= 1'b0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_opcode <= ADD;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        alu_a      <= x[7:0];
                        alu_b      <= y_eff[7:0];
                        alu_opcode <= is_sub(op16) ? SUB : ADD;
                        alu_en     <= 1'b1;
                    end
                end
                LO: begin
                    alu_a <= x_q[15:8];
                    alu_b <= y_q[15:8];
                end
                HI: begin
                    // A low-byte carry/borrow is folded into the high byte by a +/-1 pass.
                    if (c0_q) begin
                        alu_a <= alu_out;
                        alu_b <= 8'h01;
                    end else begin
                        alu_en <= 1'b0;
                        done   <= 1'b1;
                        result <= r_next;
                        flags  <= flags_next;
                    end
                end
                FIX: begin
                    alu_en <= 1'b0;
                    done   <= 1'b1;
                    result <= r_next;
                    flags  <= flags_next;
                end
                default: ;
            endcase
        end
    end

endmodule
